pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Program-counter sequencer for the fetch stage: owns the PC register and selects the next PC.
//  Sources: program base address, PC+1, or the absolute branch target from the PC lookup table.
//  Runs one of three programs per Start/Done handshake with the testbench/top level.
//  Counts executed cycles per program run.
// PARAMETERS
//  PC_W        10     PC / instruction-memory address width
//  CNT_W       16     cycle-counter width
//  PROG0_BASE  10'd0  first instruction of program 1
//  PROG1_BASE  10'd0  first instruction of program 2 (overridden at top level)
//  PROG2_BASE  10'd0  first instruction of program 3 (overridden at top level)
// PORTS
//  Clk         in   1      system clock, rising edge
//  Reset       in   1      asynchronous, active-low reset
//  Start       in   1      begin program run; sampled in IDLE or DONE only
//  ProgSel     in   2      program to run: 0/1/2; 3 = invalid
//  Halt        in   1      decoder: instruction at PC is halt
//  Stall       in   1      hold PC this cycle
//  BranchEn    in   1      decoder: instruction at PC is a LUT branch
//  BranchCond  in   1      branch condition flag from ALU
//  LutTarget   in   PC_W   absolute target from PC LUT (already indexed by instr immediate)
//  PC          out  PC_W   current fetch address
//  Running     out  1      1 while in RUN
//  Done        out  1      1 while in DONE (program finished)
//  CycleCount  out  CNT_W  cycles spent in RUN for current/last run
// BEHAVIOUR
//  Reset (async assert, sync-deasserted upstream):
//   state=IDLE, PC=0, Running=0, Done=0, CycleCount=0.
//  States: IDLE, RUN, DONE. Running/Done are registered decodes of the state.
//  IDLE:
//   Start=1 & ProgSel<3 -> PC<=PROGn_BASE, CycleCount<=0, state<=RUN.
//   Start=1 & ProgSel=3 -> ignored, remain IDLE, PC unchanged.
//  RUN (every cycle CycleCount<=CycleCount+1, saturating at all-ones).
//   Next-PC priority, highest first:
//   1 Halt=1                          -> PC holds, state<=DONE (Halt beats Stall/Branch)
//   2 Stall=1                         -> PC holds
//   3 BranchEn=1 & BranchCond=1       -> PC<=LutTarget
//   4 otherwise (incl. BranchEn & !BranchCond) -> PC<=PC+1, modulo 2^PC_W
//     (1023 -> 0; wrap is not an error)
//   Start is ignored in RUN. ProgSel is ignored outside the Start cycle.
//  DONE:
//   PC and CycleCount hold. Done=1 until a valid Start.
//   Valid Start -> same action as IDLE (direct DONE->RUN, no pass through IDLE).
//   Invalid Start -> stay DONE.
//  Latency:
//   PC = base one cycle after the Start edge; Running rises the same edge.
//   Done rises one cycle after the edge on which Halt is sampled.
//  CycleCount at DONE = number of RUN cycles, including the Halt cycle.
//  Reset asserted mid-run -> immediate return to reset values; no partial completion.
//  LutTarget is used only on a taken branch; X on it otherwise must not propagate.
// TESTING
//  1 Reset low mid-RUN at PC=37 -> PC=0, IDLE, Running=0, Done=0, CycleCount=0 immediately.
//  2 PROG2_BASE=231; Start, ProgSel=2; no branches; Halt on 5th RUN cycle
//    -> PC sequence 231..235, Done=1, PC=235, CycleCount=5.
//  3 In RUN at PC=20, BranchEn=1:
//    BranchCond=1, LutTarget=15 -> PC=15.
//    BranchCond=0 -> PC=21.
//  4 Stall=1 for 3 cycles at PC=50 -> PC stays 50, CycleCount +3.
//    Stall & Halt same cycle -> DONE.
//  5 PC=1023 with no branch -> next PC=0.
//    Start with ProgSel=3 in IDLE and in DONE -> no state change.
//  6 Start pulsed during RUN -> ignored.
//    Start in DONE with ProgSel=0 -> next cycle PC=PROG0_BASE, Running=1, Done=0, CycleCount=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch-stage program-counter sequencer: owns the PC, selects base / PC+1 / LUT branch target,
// and runs one program per Start/Done handshake while counting the RUN cycles of each run.
module pc_sequencer #(
  parameter int              PC_W       = 10,
  parameter int              CNT_W      = 16,
  parameter logic [PC_W-1:0] PROG0_BASE = 10'd0,
  parameter logic [PC_W-1:0] PROG1_BASE = 10'd0,
  parameter logic [PC_W-1:0] PROG2_BASE = 10'd0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       ProgSel,
  input  logic             Halt,
  input  logic             Stall,
  input  logic             BranchEn,
  input  logic             BranchCond,
  input  logic [PC_W-1:0]  LutTarget,
  output logic [PC_W-1:0]  PC,
  output logic             Running,
  output logic             Done,
  output logic [CNT_W-1:0] CycleCount
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [PC_W-1:0]  PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  state_t           state_s;
  logic [PC_W-1:0]  pc_s;
  logic [PC_W-1:0]  base_s;
  logic [CNT_W-1:0] cnt_s;
  logic             start_ok_s;

  // Program base lookup; ProgSel=3 never reaches the PC because start_ok_s gates it.
  always_comb begin
    base_s     = PC;
    start_ok_s = Start & (ProgSel != 2'd3);
    case (ProgSel)
      2'd0:    base_s = PROG0_BASE;
      2'd1:    base_s = PROG1_BASE;
      2'd2:    base_s = PROG2_BASE;
      default: base_s = PC;
    endcase
  end

  // Next-state, next-PC and cycle-count selection.
  always_comb begin
    state_s = state_r;
    pc_s    = PC;
    cnt_s   = CycleCount;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start_ok_s) begin
          state_s = ST_RUN;
          pc_s    = base_s;
          cnt_s   = {CNT_W{1'b0}};
        end else begin
          state_s = state_r;
        end
      end
      ST_RUN: begin
        if (CycleCount == {CNT_W{1'b1}}) begin
          cnt_s = CycleCount;
        end else begin
          cnt_s = CycleCount + CNT_ONE;
        end
        // Halt outranks Stall, which outranks a taken branch; LutTarget only muxed in when taken.
        if (Halt) begin
          state_s = ST_DONE;
        end else if (Stall) begin
          pc_s = PC;
        end else if (BranchEn && BranchCond) begin
          pc_s = LutTarget;
        end else begin
          pc_s = PC + PC_ONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        pc_s    = {PC_W{1'b0}};
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, PC, counter and registered status decodes.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r    <= ST_IDLE;
      PC         <= {PC_W{1'b0}};
      CycleCount <= {CNT_W{1'b0}};
      Running    <= 1'b0;
      Done       <= 1'b0;
    end else begin
      state_r    <= state_s;
      PC         <= pc_s;
      CycleCount <= cnt_s;
      Running    <= (state_s == ST_RUN);
      Done       <= (state_s == ST_DONE);
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the sequencing rules.
module tb_pc_sequencer;
  localparam logic [9:0] B0 = 10'd12;
  localparam logic [9:0] B1 = 10'd30;
  localparam logic [9:0] B2 = 10'd231;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] sel = 2'd0;
  logic       halt = 1'b0, stall = 1'b0, br = 1'b0, cond = 1'b0;
  logic [9:0] lut = 10'd0;
  logic [9:0] pc;
  logic       running, done;
  logic [15:0] cyc;

  int checks = 0;
  int failures = 0;
  int m_state, m_pc, m_cnt;   // model: 0 idle, 1 run, 2 done

  always #5 clk = ~clk;

  pc_sequencer #(
    .PC_W(10), .CNT_W(16), .PROG0_BASE(B0), .PROG1_BASE(B1), .PROG2_BASE(B2)
  ) dut (
    .Clk(clk), .Reset(rst_n), .Start(start), .ProgSel(sel), .Halt(halt), .Stall(stall),
    .BranchEn(br), .BranchCond(cond), .LutTarget(lut), .PC(pc), .Running(running),
    .Done(done), .CycleCount(cyc)
  );

  function automatic int base_of(input int s);
    if (s == 0) return int'(B0);
    else if (s == 1) return int'(B1);
    else return int'(B2);
  endfunction

  task automatic model_reset();
    m_state = 0; m_pc = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    if (m_state != 1) begin
      if (start && sel != 2'd3) begin
        m_state = 1; m_pc = base_of(int'(sel)); m_cnt = 0;
      end
    end else begin
      m_cnt = (m_cnt + 1 > 65535) ? 65535 : m_cnt + 1;
      if (halt) m_state = 2;
      else if (stall) m_pc = m_pc;
      else if (br && cond) m_pc = int'(lut);
      else m_pc = (m_pc + 1) % 1024;
    end
  endtask

  task automatic step(input logic st, input logic [1:0] ps, input logic h, input logic sl,
                      input logic b, input logic c, input logic [9:0] lt);
    @(negedge clk);
    start = st; sel = ps; halt = h; stall = sl; br = b; cond = c; lut = lt;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    #2;
    checks++;
    if ({pc, running, done, cyc} !== {10'd0, 1'b0, 1'b0, 16'd0}) begin
      failures++;
      $display("FAIL reset_values got pc=%0d run=%b done=%b cyc=%0d want all zero", pc, running, done, cyc);
    end
    @(negedge clk) rst_n = 1'b1;
    step(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'bx);
    checks++;
    if ({pc, running, done, cyc} !== {10'd0, 1'b0, 1'b0, 16'd0}) begin
      failures++;
      $display("FAIL idle_hold got pc=%0d run=%b done=%b cyc=%0d want all zero", pc, running, done, cyc);
    end
  endtask

  task automatic test_prog2();
    step(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 10'bx);
    for (int i = 1; i <= 5; i++) begin
      checks++;
      if (pc !== 10'(230 + i) || running !== 1'b1) begin
        failures++;
        $display("FAIL prog2_seq cycle %0d got pc=%0d run=%b want pc=%0d run=1", i, pc, running, 230 + i);
      end
      step(1'b0, 2'($urandom_range(0, 3)), (i == 5), 1'b0, 1'b0, 1'b0, 10'bx);
    end
    checks++;
    if ({pc, running, done, cyc} !== {10'd235, 1'b0, 1'b1, 16'd5}) begin
      failures++;
      $display("FAIL prog2_done got pc=%0d run=%b done=%b cyc=%0d want pc=235 run=0 done=1 cyc=5", pc, running, done, cyc);
    end
  endtask

  task automatic test_branch();
    step(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'bx);
    step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 10'd20);
    step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 10'd15);
    checks++;
    if (pc !== 10'd15) begin
      failures++;
      $display("FAIL branch_taken got pc=%0d want 15", pc);
    end
    step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 10'd20);
    step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 10'($urandom));
    checks++;
    if (pc !== 10'd21 || cyc !== 16'd4) begin
      failures++;
      $display("FAIL branch_not_taken got pc=%0d cyc=%0d want pc=21 cyc=4", pc, cyc);
    end
    step(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 10'bx);
  endtask

  task automatic test_stall();
    step(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 10'bx);
    step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 10'd50);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 2'd0, 1'b0, 1'b1, 1'($urandom), 1'($urandom), 10'($urandom));
      checks++;
      if (pc !== 10'd50 || cyc !== 16'(2 + i)) begin
        failures++;
        $display("FAIL stall_hold got pc=%0d cyc=%0d want pc=50 cyc=%0d", pc, cyc, 2 + i);
      end
    end
    step(1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 10'd99);
    checks++;
    if ({pc, running, done, cyc} !== {10'd50, 1'b0, 1'b1, 16'd5}) begin
      failures++;
      $display("FAIL stall_halt got pc=%0d run=%b done=%b cyc=%0d want pc=50 done=1 cyc=5", pc, running, done, cyc);
    end
  endtask

  task automatic test_wrap_invalid();
    step(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 10'bx);
    step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 10'd1023);
    step(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 10'bx);
    checks++;
    if (pc !== 10'd0) begin
      failures++;
      $display("FAIL pc_wrap got pc=%0d want 0", pc);
    end
    step(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 10'bx);
    step(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 10'bx);
    checks++;
    if ({pc, running, done, cyc} !== {10'd0, 1'b0, 1'b1, 16'd3}) begin
      failures++;
      $display("FAIL invalid_in_done got pc=%0d run=%b done=%b cyc=%0d want pc=0 done=1 cyc=3", pc, running, done, cyc);
    end
    @(negedge clk) rst_n = 1'b0;
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    step(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 10'bx);
    checks++;
    if ({pc, running, done, cyc} !== {10'd0, 1'b0, 1'b0, 16'd0}) begin
      failures++;
      $display("FAIL invalid_in_idle got pc=%0d run=%b done=%b cyc=%0d want all zero", pc, running, done, cyc);
    end
  endtask

  task automatic test_start_in_run();
    step(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 10'bx);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b0, 1'b0, 10'bx);
      checks++;
      if (pc !== 10'(31 + i) || running !== 1'b1) begin
        failures++;
        $display("FAIL start_in_run got pc=%0d run=%b want pc=%0d run=1", pc, running, 31 + i);
      end
    end
    step(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 10'bx);
    step(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'bx);
    checks++;
    if ({pc, running, done, cyc} !== {B0, 1'b1, 1'b0, 16'd0}) begin
      failures++;
      $display("FAIL restart_from_done got pc=%0d run=%b done=%b cyc=%0d want pc=%0d run=1 done=0 cyc=0", pc, running, done, cyc, B0);
    end
  endtask

  task automatic test_reset_midrun();
    step(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 10'bx);
    step(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 10'bx);
    for (int i = 0; i < 7; i++) step(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'bx);
    checks++;
    if (pc !== 10'd37) begin
      failures++;
      $display("FAIL midrun_setup got pc=%0d want 37", pc);
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({pc, running, done, cyc} !== {10'd0, 1'b0, 1'b0, 16'd0}) begin
      failures++;
      $display("FAIL async_reset got pc=%0d run=%b done=%b cyc=%0d want all zero", pc, running, done, cyc);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic b, c;
    for (int i = 0; i < 400; i++) begin
      b = 1'($urandom); c = 1'($urandom);
      step(($urandom_range(0, 9) == 0), 2'($urandom_range(0, 3)), ($urandom_range(0, 24) == 0),
           ($urandom_range(0, 3) == 0), b, c, (b && c) ? 10'($urandom) : 10'bx);
      checks++;
      if ({pc, running, done, cyc} !== {10'(m_pc), (m_state == 1), (m_state == 2), 16'(m_cnt)}) begin
        failures++;
        $display("FAIL random_%0d got pc=%0d run=%b done=%b cyc=%0d want pc=%0d run=%b done=%b cyc=%0d",
                 i, pc, running, done, cyc, m_pc, (m_state == 1), (m_state == 2), m_cnt);
      end
    end
  endtask

  task automatic test_saturate();
    step(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 10'bx);
    step(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 10'bx);
    for (int i = 0; i < 65540; i++) step(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 10'bx);
    checks++;
    if ({pc, running, cyc} !== {B1, 1'b1, 16'hFFFF}) begin
      failures++;
      $display("FAIL cnt_saturate got pc=%0d run=%b cyc=%0d want pc=%0d run=1 cyc=65535", pc, running, cyc, B1);
    end
    step(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 10'bx);
    checks++;
    if ({done, cyc} !== {1'b1, 16'(m_cnt)}) begin
      failures++;
      $display("FAIL cnt_sat_halt got done=%b cyc=%0d want done=1 cyc=%0d", done, cyc, m_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_prog2();
    test_branch();
    test_stall();
    test_wrap_invalid();
    test_start_in_run();
    test_reset_midrun();
    test_random();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
